console_writer: RTL and testbench

// - Write side of the text-console video RAM; the console display path reads the same VRAM.
// - Accepts a byte stream of character codes (e.g. from a UART receiver) on a valid/ready handshake.
// - Keeps a text cursor and writes each glyph code into VRAM at cursor_y*screenW+cursor_x.
// - Handles CR, LF, BS and FF, line wrap, clear-next-line on row advance and full-screen clear.

---
 rtl/console_writer_pkg.sv | 33 +++
 rtl/vram_addr_calc.sv | 12 +
 rtl/console_writer.sv | 145 ++++++++++++++
 tb/tb_console_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_writer_pkg.sv
// Shared constants, control codes, state encoding and write payload for the text-console VRAM.
// The display-side reader imports the same package.
package console_writer_pkg;

   localparam int unsigned SCREEN_W = 40;
   localparam int unsigned SCREEN_H = 30;
   localparam int unsigned CELLS    = SCREEN_W * SCREEN_H;
   localparam int unsigned AW       = 11;
   localparam int unsigned CX_W     = 6;
   localparam int unsigned CY_W     = 5;

   localparam logic [7:0] FILL  = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_FF = 8'h0C;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLR_LINE   = 2'd1,
      CLR_SCREEN = 2'd2
   } state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } vram_wr_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/vram_addr_calc.sv
// Combinational cell address y*SCREEN_W + x, shared by the console writer and the display reader.
module vram_addr_calc
   import console_writer_pkg::*;
(
   input  logic [CX_W-1:0] x,
   input  logic [CY_W-1:0] y,
   output logic [AW-1:0]   addr_c
);

   assign addr_c = AW'(AW'(y) * AW'(SCREEN_W)) + AW'(x);

endmodule

// File: rtl/console_writer.sv
// Write side of the text-console VRAM: cursor tracking, control-code handling,
// line clear on row advance and full-screen clear, with registered VRAM write port.
module console_writer
   import console_writer_pkg::*;
(
   input  logic            px_clk,
   input  logic            reset,
   input  logic [7:0]      char_i,
   input  logic            char_valid_i,
   output logic            char_ready_o,
   output logic [AW-1:0]   wr_addr_vram,
   output logic [7:0]      wr_data_vram,
   output logic            wr_en_vram,
   output logic [CX_W-1:0] cursor_x,
   output logic [CY_W-1:0] cursor_y,
   output logic            busy
);

   state_t          state, state_n;
   logic [CX_W-1:0] cx_n;
   logic [CY_W-1:0] cy_n, cy_inc;
   logic [AW-1:0]   cnt, cnt_n;
   logic            wr_en_n;
   vram_wr_t        wr_q, wr_n;
   logic [CX_W-1:0] calc_x;
   logic [AW-1:0]   cell_addr;
   logic            accept;

   assign wr_addr_vram = wr_q.addr;
   assign wr_data_vram = wr_q.data;
   assign accept       = char_valid_i && char_ready_o;
   assign cy_inc       = (cursor_y == CY_W'(SCREEN_H - 1)) ? '0 : cursor_y + CY_W'(1);

   // Column fed to the address helper: clear counter, backspace target, or the cursor.
   always_comb begin
      calc_x = cursor_x;
      if (state == CLR_LINE) begin
         calc_x = CX_W'(cnt);
      end else if (char_i == CH_BS) begin
         calc_x = cursor_x - CX_W'(1);
      end
   end

   vram_addr_calc u_addr (
      .x      (calc_x),
      .y      (cursor_y),
      .addr_c (cell_addr)
   );

   // Next-state, cursor and write decision.
   always_comb begin
      state_n = state;
      cx_n    = cursor_x;
      cy_n    = cursor_y;
      cnt_n   = cnt;
      wr_en_n = 1'b0;
      wr_n    = '{addr: cell_addr, data: FILL};

      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_printable(char_i)) begin
                  wr_en_n = 1'b1;
                  wr_n    = '{addr: cell_addr, data: char_i};
                  if (cursor_x == CX_W'(SCREEN_W - 1)) begin
                     cx_n    = '0;
                     cy_n    = cy_inc;
                     cnt_n   = '0;
                     state_n = CLR_LINE;
                  end else begin
                     cx_n = cursor_x + CX_W'(1);
                  end
               end else if (char_i == CH_CR) begin
                  cx_n = '0;
               end else if (char_i == CH_LF) begin
                  cx_n    = '0;
                  cy_n    = cy_inc;
                  cnt_n   = '0;
                  state_n = CLR_LINE;
               end else if (char_i == CH_BS) begin
                  if (cursor_x != '0) begin
                     cx_n    = cursor_x - CX_W'(1);
                     wr_en_n = 1'b1;
                  end
               end else if (char_i == CH_FF) begin
                  cnt_n   = '0;
                  state_n = CLR_SCREEN;
               end
            end
         end

         CLR_LINE: begin
            wr_en_n = 1'b1;
            if (cnt == AW'(SCREEN_W - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + AW'(1);
            end
         end

         CLR_SCREEN: begin
            wr_en_n = 1'b1;
            wr_n    = '{addr: cnt, data: FILL};
            if (cnt == AW'(CELLS - 1)) begin
               cnt_n   = '0;
               cx_n    = '0;
               cy_n    = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + AW'(1);
            end
         end

         default: begin
            state_n = CLR_SCREEN;
            cnt_n   = '0;
         end
      endcase
   end

   // State, cursor and output registers; ready/busy track the state being entered.
   always_ff @(posedge px_clk) begin
      if (reset) begin
         state        <= CLR_SCREEN;
         cursor_x     <= '0;
         cursor_y     <= '0;
         cnt          <= '0;
         wr_en_vram   <= 1'b0;
         wr_q         <= '0;
         char_ready_o <= 1'b0;
         busy         <= 1'b1;
      end else begin
         state        <= state_n;
         cursor_x     <= cx_n;
         cursor_y     <= cy_n;
         cnt          <= cnt_n;
         wr_en_vram   <= wr_en_n;
         wr_q         <= wr_n;
         char_ready_o <= (state_n == IDLE);
         busy         <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a cursor model pushes expected VRAM writes,
// a negedge monitor pops and compares every write the DUT produces.
module tb_console_writer;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } exp_t;

   logic        px_clk = 1'b0;
   logic        reset;
   logic [7:0]  char_i;
   logic        char_valid_i;
   logic        char_ready_o;
   logic [10:0] wr_addr_vram;
   logic [7:0]  wr_data_vram;
   logic        wr_en_vram;
   logic [5:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        sb[$];
   int unsigned mx = 0;
   int unsigned my = 0;

   console_writer dut (
      .px_clk       (px_clk),
      .reset        (reset),
      .char_i       (char_i),
      .char_valid_i (char_valid_i),
      .char_ready_o (char_ready_o),
      .wr_addr_vram (wr_addr_vram),
      .wr_data_vram (wr_data_vram),
      .wr_en_vram   (wr_en_vram),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .busy         (busy)
   );

   always #5 px_clk = ~px_clk;

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge px_clk);
      #1;
   endtask

   // Every VRAM write must match the head of the scoreboard.
   always @(negedge px_clk) begin
      if (wr_en_vram === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_wr", 32'(wr_addr_vram), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr_vram), e.addr);
            check("wr_data", 32'(wr_data_vram), e.data);
         end
      end
   end

   task automatic push_fill(input int unsigned first, input int unsigned count);
      for (int unsigned i = 0; i < count; i++) sb.push_back('{first + i, 32'h20});
   endtask

   task automatic model_char(input logic [7:0] ch);
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         sb.push_back('{my * 40 + mx, 32'(ch)});
         if (mx == 39) begin
            mx = 0;
            my = (my + 1) % 30;
            push_fill(my * 40, 40);
         end else begin
            mx++;
         end
      end else if (ch == 8'h0D) begin
         mx = 0;
      end else if (ch == 8'h0A) begin
         mx = 0;
         my = (my + 1) % 30;
         push_fill(my * 40, 40);
      end else if (ch == 8'h08) begin
         if (mx > 0) begin
            mx--;
            sb.push_back('{my * 40 + mx, 32'h20});
         end
      end else if (ch == 8'h0C) begin
         push_fill(0, 1200);
         mx = 0;
         my = 0;
      end
   endtask

   // Present a character, hold it until ready, return just after the accepting edge.
   task automatic send(input logic [7:0] ch);
      int n;
      model_char(ch);
      char_i       = ch;
      char_valid_i = 1'b1;
      n = 0;
      while (!char_ready_o && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) check("send_ready", 32'(char_ready_o), 1);
      tick();
      char_valid_i = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!char_ready_o && n < 5000) begin
         tick();
         n++;
      end
      check("ready_wait", 32'(char_ready_o), 1);
   endtask

   task automatic check_cursor(input string tag, input int unsigned x, input int unsigned y);
      check({tag, "_x"}, 32'(cursor_x), x);
      check({tag, "_y"}, 32'(cursor_y), y);
   endtask

   task automatic drain(input string tag);
      tick();
      tick();
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic full_clear_after_reset(input string tag);
      int n;
      sb.delete();
      push_fill(0, 1200);
      mx = 0;
      my = 0;
      reset = 1'b0;
      wait_ready(n);
      check({tag, "_ready_low"}, n, 1200);
      check_cursor(tag, 0, 0);
      drain(tag);
   endtask

   initial begin
      int n;
      reset        = 1'b1;
      char_i       = 8'h00;
      char_valid_i = 1'b0;
      repeat (4) tick();
      check("rst_ready", 32'(char_ready_o), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_wr_en", 32'(wr_en_vram), 0);
      check_cursor("rst", 0, 0);

      // Power-on clear.
      full_clear_after_reset("por");

      // Single glyph at home.
      send(8'h41);
      check("a_wr_en", 32'(wr_en_vram), 1);
      check("a_addr", 32'(wr_addr_vram), 0);
      check("a_data", 32'(wr_data_vram), 32'h41);
      check_cursor("a", 1, 0);
      send(8'h0D);
      check_cursor("cr", 0, 0);

      // Stream a full row back-to-back, wrap into row 1.
      for (int i = 0; i < 40; i++) send(8'(8'h30 + i));
      check("wrap_glyph_addr", 32'(wr_addr_vram), 39);
      check("wrap_glyph_data", 32'(wr_data_vram), 32'h57);
      check("wrap_busy", 32'(busy), 1);
      wait_ready(n);
      check("wrap_ready_low", n, 40);
      check_cursor("wrap", 0, 1);
      drain("wrap");

      // Move to (7,29), then LF wraps to row 0 with no glyph.
      for (int i = 0; i < 28; i++) begin
         send(8'h0A);
         wait_ready(n);
      end
      for (int i = 0; i < 7; i++) send(8'h61);
      check_cursor("pos729", 7, 29);
      send(8'h0A);
      check("lf_no_glyph", 32'(wr_en_vram), 0);
      wait_ready(n);
      check("lf_ready_low", n, 40);
      check_cursor("lf_wrap", 0, 0);
      drain("lf_wrap");

      // Backspace at (5,2) and at column 0.
      send(8'h0A);
      wait_ready(n);
      send(8'h0A);
      wait_ready(n);
      for (int i = 0; i < 5; i++) send(8'h62);
      check_cursor("pos52", 5, 2);
      send(8'h08);
      check("bs_wr_en", 32'(wr_en_vram), 1);
      check("bs_addr", 32'(wr_addr_vram), 84);
      check("bs_data", 32'(wr_data_vram), 32'h20);
      check_cursor("bs", 4, 2);
      send(8'h0D);
      send(8'h08);
      check("bs0_wr_en", 32'(wr_en_vram), 0);
      check_cursor("bs0", 0, 2);

      // Unhandled codes are consumed without effect.
      send(8'h01);
      send(8'h7F);
      send(8'h80);
      check("ign_ready", 32'(char_ready_o), 1);
      check_cursor("ign", 0, 2);
      drain("ign");

      // FF from the last cell.
      for (int i = 0; i < 27; i++) begin
         send(8'h0A);
         wait_ready(n);
      end
      for (int i = 0; i < 39; i++) send(8'h7E);
      check_cursor("pos3929", 39, 29);
      send(8'h0C);
      wait_ready(n);
      check("ff_ready_low", n, 1200);
      check_cursor("ff", 0, 0);
      drain("ff");

      // Reset in the middle of a screen clear restarts it from 0.
      send(8'h0C);
      n = 0;
      while (!(wr_en_vram && wr_addr_vram == 11'd600) && n < 5000) begin
         tick();
         n++;
      end
      check("mid_addr", 32'(wr_addr_vram), 600);
      reset = 1'b1;
      tick();
      tick();
      check("mid_rst_ready", 32'(char_ready_o), 0);
      check("mid_rst_wr_en", 32'(wr_en_vram), 0);
      full_clear_after_reset("mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
